shift_pattern_detector: RTL
===========================

Name: shift_pattern_detector

Overview:
Parametrised shift register with a built-in tick divider, selectable shift direction, parallel load, and a runtime-programmable serial pattern detector. The detector watches the bit stream leaving the register and counts matches, in overlapping or non-overlapping mode. The block runs entirely in the clock_50_MHz domain and gates all activity with a divider tick, so board top levels never clock logic from a divider bit. Outputs drive LEDR, HEX digits and a match indicator.

Parameters:
WIDTH, 10, shift register width (>=2)
DIV_LOG2, 25, tick period = 2**DIV_LOG2 clocks; 0 = tick every clock
PAT_LEN, 4, pattern length in bits (1..WIDTH)
OVERLAP, 1, 1 = overlapping matches; 0 = history restarts after each match
CNT_W, 8, match counter width; counter saturates

Ports:
clock_50_MHz  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  shift on tick when high
dir  input  1  0 = shift right (in at MSB, out at bit 0); 1 = shift left (in at bit 0, out at MSB)
serial_in  input  1  bit entering the register
load  input  1  synchronous parallel load, not gated by tick
load_data  input  WIDTH  parallel load value
pattern  input  PAT_LEN  target pattern; pattern[PAT_LEN-1] is the oldest bit
clear  input  1  synchronous clear of match_count
tick  output  1  one-clock divider pulse
data  output  WIDTH  register contents
serial_out  output  1  dir ? data[WIDTH-1] : data[0], combinational
match_pulse  output  1  one-clock pulse per match
match_hold  output  1  level: last shift event produced a match
match_count  output  CNT_W  saturating match count

Behaviour:
- Reset (async, all regs): div counter 0; data = 1 followed by WIDTH-1 zeros (MSB set); hist 0; fill 0; tick, match_pulse, match_hold 0; match_count 0.
- Divider: counter increments every clock and wraps. tick = 1 for the single cycle in which counter == all ones, so the first tick occurs in clock 2**DIV_LOG2 after reset release. With DIV_LOG2 = 0, tick is constantly 1 after reset.
- Shift event = tick & enable & !load.
  - dir=0: data <= {serial_in, data[WIDTH-1:1]}.
  - dir=1: data <= {data[WIDTH-2:0], serial_in}.
- load = 1: data <= load_data on that edge regardless of tick. Load has priority over shift. hist, fill and counters are unaffected.
- Detector, on each shift event only:
  - The bit shifted out is serial_out sampled before the edge.
  - hist <= {hist[PAT_LEN-2:0], bit}. fill <= min(fill+1, PAT_LEN).
  - Hit when (fill+1 >= PAT_LEN) and next hist == pattern.
- On a hit:
  - match_pulse = 1 for exactly the cycle after the edge.
  - match_hold = 1 until the next shift event, which re-evaluates it.
  - match_count increments, saturating at 2**CNT_W-1.
  - If OVERLAP = 0, fill <= 0, so no new match is possible until PAT_LEN fresh bits have arrived.
- Non-hit shift event: match_hold <= 0.
- pattern is compared live. A pattern change takes effect at the next shift event and never retroactively.
- clear: match_count <= 0. If clear and a hit occur on the same edge, the count ends at 1. clear has no effect on hist or fill.
- enable low: data, hist and fill hold. tick keeps running.
- A mid-operation reset returns every register to its reset value immediately, with no pending match.

Test Plan:
1. Reset, DIV_LOG2=2, WIDTH=10. Hold reset_n low, release, enable=0. Required: data=10'h200, match_count=0, serial_out=0, tick high in clocks 4, 8, 12 only, data unchanged.
2. Walk the reset bit. DIV_LOG2=0, dir=0, serial_in=0, enable=1, pattern=4'b0001. Required: serial_out=1 after 9 shifts; on the 10th shift match_pulse pulses once, match_hold=1, match_count=1. On the 11th shift match_hold=0.
3. Overlap mode. DIV_LOG2=0, pattern=4'b1010, load 10'b00_0101_0101, then 10 shifts right. Required with OVERLAP=1: matches after out-bits 4, 6, 8, match_count=3. Required with OVERLAP=0: matches after 4 and 8, match_count=2.
4. Left shift. dir=1, load 10'b10_1000_0000, serial_in=0, pattern=2'b10, PAT_LEN=2. Required: out stream 1,0,1,0, matches on shifts 2 and 4.
5. Saturation and clear. CNT_W=2, drive 5 matches. Required: match_count=3 and held. Then clear on the same edge as a 6th match. Required: match_count=1.
6. Collisions. load=1 on a tick with enable=1. Required: data=load_data, no shift, no detector update. Assert reset_n mid-stream with match_hold=1. Required: all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/shift_pattern_detector.sv
// shift_pattern_detector: tick-gated shift register with a runtime-programmable
// serial pattern detector and saturating match counter.
module shift_pattern_detector #(
  parameter int WIDTH    = 10,
  parameter int DIV_LOG2 = 25,
  parameter int PAT_LEN  = 4,
  parameter int OVERLAP  = 1,
  parameter int CNT_W    = 8
) (
  input  logic               clock_50_MHz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               dir,
  input  logic               serial_in,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_data,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               clear,
  output logic               tick,
  output logic [WIDTH-1:0]   data,
  output logic               serial_out,
  output logic               match_pulse,
  output logic               match_hold,
  output logic [CNT_W-1:0]   match_count
);
  localparam int DW = DIV_LOG2 > 0 ? DIV_LOG2 : 1;
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW:0] PL = (FW + 1)'(PAT_LEN);
  logic [DW-1:0]      r_div;
  logic               r_tick;
  logic [WIDTH-1:0]   r_data;
  logic [PAT_LEN-1:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic               r_pulse;
  logic               r_hold;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_shift;
  logic               w_hit;
  logic               w_full;
  logic [PAT_LEN-1:0] w_hist_n;
  logic [FW:0]        w_fill_inc;
  logic [FW-1:0]      w_fill_n;
  logic [WIDTH-1:0]   w_data_sh;
  assign tick        = r_tick;
  assign data        = r_data;
  assign match_pulse = r_pulse;
  assign match_hold  = r_hold;
  assign match_count = r_cnt;
  assign serial_out  = dir ? r_data[WIDTH-1] : r_data[0];
  assign w_shift     = r_tick & enable & ~load;
  assign w_hist_n    = PAT_LEN'({r_hist, serial_out});
  assign w_fill_inc  = {1'b0, r_fill} + 1'b1;
  assign w_full      = w_fill_inc >= PL;
  assign w_hit       = w_shift && w_full && (w_hist_n == pattern);
  assign w_fill_n    = (w_hit && OVERLAP == 0) ? '0 : w_full ? PL[FW-1:0] : w_fill_inc[FW-1:0];
  assign w_data_sh   = dir ? {r_data[WIDTH-2:0], serial_in} : {serial_in, r_data[WIDTH-1:1]};
  // Tick is registered from the all-ones counter state, so it lands in clock 2**DIV_LOG2.
  always_ff @(posedge clock_50_MHz or negedge reset_n)
    if (!reset_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= (DIV_LOG2 == 0) || (&r_div);
    end
  always_ff @(posedge clock_50_MHz or negedge reset_n)
    if (!reset_n)
      r_data <= {1'b1, {(WIDTH-1){1'b0}}};
    else if (load)
      r_data <= load_data;
    else if (w_shift)
      r_data <= w_data_sh;
  always_ff @(posedge clock_50_MHz or negedge reset_n)
    if (!reset_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pulse <= 1'b0;
      r_hold  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pulse <= w_hit;
      if (w_shift) begin
        r_hist <= w_hist_n;
        r_fill <= w_fill_n;
        r_hold <= w_hit;
      end
      // A clear coinciding with a hit leaves the count at one.
      r_cnt <= clear ? CNT_W'(w_hit) : (w_hit && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
endmodule
